// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: shared types, constants and reference model for the gate vector sequencer.
package gate_seq_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam int NUM_VECTORS = 16;
  localparam int ERR_W = 5;
  function automatic logic gate_expected(input logic [3:0] vec);
    return (vec[3] & vec[2]) | (vec[1] & vec[0]);
  endfunction
endpackage

// File: rtl/gate_vector_sequencer_if.sv
// gate_seq_if: control and gate-under-test signals of the sequencer; GATE_SEQ_FAIL_CAPTURE_EN adds fail capture.
interface gate_seq_if;
  import gate_seq_pkg::*;
  logic start, e, i, m, r, l, busy, done, pass;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0] vec;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
  logic fail_valid;
  logic [3:0] fail_vec;
  modport master (output start, e, input i, m, r, l, busy, done, pass, err_cnt, vec, fail_valid, fail_vec);
  modport slave (input start, e, output i, m, r, l, busy, done, pass, err_cnt, vec, fail_valid, fail_vec);
`else
  modport master (output start, e, input i, m, r, l, busy, done, pass, err_cnt, vec);
  modport slave (input start, e, output i, m, r, l, busy, done, pass, err_cnt, vec);
`endif
endinterface

// File: rtl/gate_seq_hold_timer.sv
// gate_seq_hold_timer: loadable down-counter holding each vector for HOLD_CYCLES cycles.
module gate_seq_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);
  logic [3:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= 4'(HOLD_CYCLES - 1);
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 4'd1;
  end
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: sweeps all 16 {i,m,r,l} vectors through the gate and counts mismatches.
// Optional GATE_SEQ_FAIL_CAPTURE_EN records the first failing vector.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  gate_seq_if.slave bus
);
  state_t r_state;
  logic [3:0] r_vec, r_stim;
  logic [ERR_W-1:0] r_err;
  logic r_pass, r_busy, r_done;
  logic w_accept, w_last, w_miss, w_zero, w_load, w_dec;
  logic [ERR_W-1:0] w_err_next;
  assign w_accept = r_state == IDLE && bus.start;
  assign w_last = r_vec == 4'(NUM_VECTORS - 1);
  assign w_miss = r_state == SAMPLE && bus.e != gate_expected(r_vec);
  assign w_err_next = r_err + ERR_W'(w_miss);
  assign w_load = w_accept || (r_state == SAMPLE && !w_last);
  assign w_dec = r_state == DRIVE;
  gate_seq_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .i_load(w_load), .i_dec(w_dec), .o_zero(w_zero)
  );
  // Outputs are registered alongside the transition so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_vec <= '0;
      r_stim <= '0;
      r_err <= '0;
      r_pass <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.start) begin
          r_state <= DRIVE;
          r_vec <= '0;
          r_stim <= '0;
          r_err <= '0;
          r_pass <= 1'b0;
          r_busy <= 1'b1;
        end
        DRIVE: if (w_zero) r_state <= SAMPLE;
        SAMPLE: begin
          r_err <= w_err_next;
          if (w_last) begin
            r_state <= DONE;
            r_stim <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= w_err_next == '0;
          end else begin
            r_state <= DRIVE;
            r_vec <= r_vec + 4'd1;
            r_stim <= r_vec + 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign {bus.i, bus.m, bus.r, bus.l} = r_stim;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.pass = r_pass;
  assign bus.err_cnt = r_err;
  assign bus.vec = r_vec;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
  logic r_fail_valid;
  logic [3:0] r_fail_vec;
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_fail_valid <= 1'b0;
      r_fail_vec <= '0;
    end else if (w_miss && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_vec <= r_vec;
    end
  end
  assign bus.fail_valid = r_fail_valid;
  assign bus.fail_vec = r_fail_vec;
`endif
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb_gate_vector_sequencer: directed sweeps against good, stuck and inverted gate models.
module tb_gate_vector_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic g;
  gate_seq_if bus();
  gate_vector_sequencer #(.HOLD_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    g = (bus.i & bus.m) | (bus.r & bus.l);
    bus.e = mode == 0 ? g : mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : ~g;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_stim"}, {28'd0, bus.i, bus.m, bus.r, bus.l}, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pass"}, bus.pass, 0);
    chk({tag, "_err"}, bus.err_cnt, 0);
    chk({tag, "_vec"}, bus.vec, 0);
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    chk({tag, "_fail_valid"}, bus.fail_valid, 0);
    chk({tag, "_fail_vec"}, bus.fail_vec, 0);
`endif
  endtask
  task automatic sweep(input int md, input int exp_err, input logic exp_pass, input int exp_fv, input bit poke);
    int k;
    logic [3:0] last_vec;
    last_vec = '0;
    mode = md;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    k = 1;
    chk("busy_after_start", bus.busy, 1);
    chk("vec_after_start", bus.vec, 0);
    while (!bus.done && k < 300) begin
      last_vec = bus.vec;
      bus.start = poke && k == 20;
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    chk("sweep_len", k, 81);
    chk("last_sample_vec", last_vec, 15);
    chk("busy_in_done", bus.busy, 0);
    chk("stim_in_done", {28'd0, bus.i, bus.m, bus.r, bus.l}, 0);
    chk("err_cnt", bus.err_cnt, exp_err);
    chk("pass", bus.pass, exp_pass);
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    chk("fail_valid", bus.fail_valid, exp_err != 0);
    chk("fail_vec", bus.fail_vec, exp_fv);
`endif
    if (poke) begin
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("err_hold", bus.err_cnt, exp_err);
    chk("pass_hold", bus.pass, exp_pass);
    if (poke) begin
      @(negedge clk);
      chk("start_in_done_ignored", bus.busy, 0);
    end
  endtask
  initial begin
    int k;
    int seen;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    sweep(0, 0, 1'b1, 0, 1'b0);
    sweep(1, 7, 1'b0, 3, 1'b0);
    sweep(2, 9, 1'b0, 0, 1'b0);
    sweep(3, 16, 1'b0, 0, 1'b0);
    mode = 1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0;
    while (bus.vec != 4'd5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reached_vec5", bus.vec, 5);
    rst = 1'b1;
    @(posedge clk);
    #1 chk_reset_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    sweep(0, 0, 1'b1, 0, 1'b0);
    sweep(0, 0, 1'b1, 0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
